// File: rtl/cache_tag_maint_ctrl_if.sv
// Bundle of command, status, tag-store maintenance and writeback signals
// between the cache control FSM, the tag store and the maintenance sequencer.
interface cache_tag_maint_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TAG_WIDTH  = 21
);
    logic                  cmd_valid;
    logic                  cmd_op;
    logic                  cmd_ready;
    logic                  rw_idle;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH+2:0] wb_count;
    logic                  sel;

    logic [ADDR_WIDTH-1:0] ri_readAddress;
    logic [1:0]            ri_readChannel;
    logic [31:0]           ri_readData;
    logic [ADDR_WIDTH-1:0] ri_writeAddress;
    logic [1:0]            ri_writeChannel;
    logic                  ri_writeEnable;
    logic [31:0]           ri_writeData;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [TAG_WIDTH-1:0]  wb_tag;
    logic [ADDR_WIDTH-1:0] wb_set;
    logic [1:0]            wb_way;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, rw_idle, ri_readData, wb_ready,
        output cmd_ready, busy, done, wb_count, sel,
        output ri_readAddress, ri_readChannel,
        output ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData,
        output wb_valid, wb_tag, wb_set, wb_way
    );

    // Requester / tag store / writeback engine side.
    modport master (
        output cmd_valid, cmd_op, rw_idle, ri_readData, wb_ready,
        input  cmd_ready, busy, done, wb_count, sel,
        input  ri_readAddress, ri_readChannel,
        input  ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData,
        input  wb_valid, wb_tag, wb_set, wb_way
    );
endinterface

// File: rtl/cache_tag_maint_ctrl.sv
// Whole-cache INVALIDATE / FLUSH sequencer: walks every set and way of the 4-way
// tag store, hands dirty valid blocks to the writeback engine, then clears the tag.
module cache_tag_maint_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TAG_WIDTH  = 21
) (
    input logic                   clk,
    input logic                   rst,
    cache_tag_maint_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StWaitIdle,
        StRead,
        StCheck,
        StWb,
        StClear,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] set_q, set_d;
    logic [1:0]            way_q, way_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH+2:0] wb_count_q, wb_count_d;
    logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;
    logic [ADDR_WIDTH-1:0] wb_set_q, wb_set_d;
    logic [1:0]            wb_way_q, wb_way_d;

    logic tag_valid;
    logic tag_dirty;
    logic last_blk;
    logic unused_rd_bits;

    assign tag_valid      = bus.ri_readData[TAG_WIDTH];
    assign tag_dirty      = bus.ri_readData[TAG_WIDTH+1];
    assign last_blk       = (set_q == {ADDR_WIDTH{1'b1}}) && (way_q == 2'd3);
    assign unused_rd_bits = ^bus.ri_readData[31:TAG_WIDTH+2];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q      <= '0;
            way_q      <= '0;
            op_q       <= 1'b0;
            wb_count_q <= '0;
            wb_tag_q   <= '0;
            wb_set_q   <= '0;
            wb_way_q   <= '0;
        end else begin
            set_q      <= set_d;
            way_q      <= way_d;
            op_q       <= op_d;
            wb_count_q <= wb_count_d;
            wb_tag_q   <= wb_tag_d;
            wb_set_q   <= wb_set_d;
            wb_way_q   <= wb_way_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) state_d = StWaitIdle;
            end
            StWaitIdle: begin
                if (bus.rw_idle) state_d = op_q ? StRead : StClear;
            end
            StRead: begin
                state_d = StCheck;
            end
            StCheck: begin
                // A dirty bit on an invalid entry is stale; treat it as clean.
                state_d = (tag_valid && tag_dirty) ? StWb : StClear;
            end
            StWb: begin
                if (bus.wb_ready) state_d = StClear;
            end
            StClear: begin
                if (last_blk) begin
                    state_d = StDone;
                end else begin
                    state_d = op_q ? StRead : StClear;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: command latch, set/way walk, victim capture, count.
    always_comb begin
        op_d       = op_q;
        set_d      = set_q;
        way_d      = way_q;
        wb_count_d = wb_count_q;
        wb_tag_d   = wb_tag_q;
        wb_set_d   = wb_set_q;
        wb_way_d   = wb_way_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    op_d       = bus.cmd_op;
                    set_d      = '0;
                    way_d      = '0;
                    wb_count_d = '0;
                end
            end
            StCheck: begin
                if (tag_valid && tag_dirty) begin
                    wb_tag_d = bus.ri_readData[TAG_WIDTH-1:0];
                    wb_set_d = set_q;
                    wb_way_d = way_q;
                end
            end
            StWb: begin
                if (bus.wb_ready) wb_count_d = wb_count_q + (ADDR_WIDTH+3)'(1);
            end
            StClear: begin
                way_d = way_q + 2'd1;
                if (way_q == 2'd3) set_d = set_q + ADDR_WIDTH'(1);
            end
            default: begin
            end
        endcase
    end

    // Moore outputs; all strobes fall straight from state so reset drops them at once.
    always_comb begin
        bus.cmd_ready      = 1'b0;
        bus.busy           = 1'b0;
        bus.sel            = 1'b0;
        bus.done           = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.ri_writeEnable = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.cmd_ready = 1'b1;
            end
            StWaitIdle: begin
                bus.busy = 1'b1;
            end
            StRead, StCheck: begin
                bus.busy = 1'b1;
                bus.sel  = 1'b1;
            end
            StWb: begin
                bus.busy     = 1'b1;
                bus.sel      = 1'b1;
                bus.wb_valid = 1'b1;
            end
            StClear: begin
                bus.busy           = 1'b1;
                bus.sel            = 1'b1;
                bus.ri_writeEnable = 1'b1;
            end
            StDone: begin
                bus.busy = 1'b1;
                bus.sel  = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.ri_readAddress  = set_q;
    assign bus.ri_readChannel  = way_q;
    assign bus.ri_writeAddress = set_q;
    assign bus.ri_writeChannel = way_q;
    assign bus.ri_writeData    = 32'd0;
    assign bus.wb_count        = wb_count_q;
    assign bus.wb_tag          = wb_tag_q;
    assign bus.wb_set          = wb_set_q;
    assign bus.wb_way          = wb_way_q;
endmodule

// File: tb/tb_cache_tag_maint_ctrl.sv
// Bench for cache_tag_maint_ctrl: tag-store model, randomized images and stalls,
// expected walk order / writeback list / latency derived from the command rules.
module tb_cache_tag_maint_ctrl;
    localparam int AW   = 2;
    localparam int TW   = 21;
    localparam int NSET = 1 << AW;
    localparam int NBLK = 4 * NSET;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_tag_maint_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();
    cache_tag_maint_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Tag store: registered set read, combinational way select.
    logic [31:0] mem   [NBLK];
    logic [31:0] img   [NBLK];
    logic [31:0] row_q [4];
    logic        load;
    always @(posedge clk) begin
        for (int w = 0; w < 4; w++) row_q[w] <= mem[{bus.ri_readAddress, 2'(w)}];
        if (load) begin
            for (int i = 0; i < NBLK; i++) mem[i] <= img[i];
        end else if (bus.ri_writeEnable) begin
            mem[{bus.ri_writeAddress, bus.ri_writeChannel}] <= bus.ri_writeData;
        end
    end
    assign bus.ri_readData = row_q[bus.ri_readChannel];

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor + writeback responder state.
    int               stall_cfg   = 0;
    int               stall_total = 0;
    int               sel_cycles  = 0;
    int               hyg_err     = 0;
    int               done_cnt    = 0;
    logic [3:0]       clr_q [$];
    logic [TW+3:0]    wb_q  [$];
    logic [TW+3:0]    exp_wb [$];

    initial begin
        int            wcnt;
        int            tgt;
        bit            in_xfer;
        bit            prev_sel;
        bit            prev_wbv;
        logic [TW+3:0] prev_pl;
        logic [TW+3:0] pl;
        bus.wb_ready = 1'b0;
        in_xfer = 0; prev_sel = 0; prev_wbv = 0; wcnt = 0; tgt = 0; prev_pl = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.wb_ready = 1'b0;
                in_xfer = 0; prev_sel = 0; prev_wbv = 0;
            end else begin
                pl = {bus.wb_tag, bus.wb_set, bus.wb_way};
                if (bus.wb_valid) begin
                    if (!in_xfer) begin
                        in_xfer = 1; wcnt = 0;
                        tgt = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
                    end
                    if (prev_wbv && pl != prev_pl) hyg_err++;
                    bus.wb_ready = (wcnt >= tgt);
                    wcnt++;
                    if (bus.wb_ready) begin
                        in_xfer = 0;
                        stall_total += wcnt;
                        wb_q.push_back(pl);
                    end
                end else begin
                    bus.wb_ready = 1'($urandom_range(0, 1));
                    in_xfer = 0;
                end
                prev_wbv = bus.wb_valid && !bus.wb_ready;
                prev_pl  = pl;
                if (bus.sel) sel_cycles++;
                if (bus.ri_writeEnable) begin
                    clr_q.push_back({bus.ri_writeAddress, bus.ri_writeChannel});
                    if (!bus.sel || bus.ri_writeData != 32'd0 || bus.wb_valid) hyg_err++;
                end
                if (bus.wb_valid && !bus.sel) hyg_err++;
                if (prev_sel && !bus.sel && bus.busy) hyg_err++;
                if (bus.done) done_cnt++;
                prev_sel = bus.sel;
            end
        end
    end

    task automatic load_image();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic clear_mon();
        sel_cycles = 0; hyg_err = 0; done_cnt = 0; stall_total = 0;
        clr_q.delete(); wb_q.delete();
    endtask

    // Issue one command; optionally hold rw_idle low and keep poking cmd_valid while busy.
    task automatic run_cmd(input bit op, input int delay, input bit poke,
                           output int bad_wait, output bit timeout);
        clear_mon();
        @(negedge clk);
        bus.rw_idle = (delay == 0); bus.cmd_valid = 1'b1; bus.cmd_op = op;
        @(negedge clk);
        bus.cmd_valid = poke; bus.cmd_op = ~op;
        bad_wait = 0;
        for (int i = 0; i < delay; i++) begin
            if (bus.sel || !bus.busy || bus.ri_writeEnable || bus.cmd_ready) bad_wait++;
            @(negedge clk);
        end
        bus.rw_idle = 1'b1;
        timeout = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (bus.done) begin timeout = 1'b0; break; end
            if (poke && bus.cmd_ready) bad_wait++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic void build_expected();
        logic [31:0] word;
        exp_wb.delete();
        for (int s = 0; s < NSET; s++) begin
            for (int w = 0; w < 4; w++) begin
                word = img[s*4 + w];
                if (word[TW] && word[TW+1]) exp_wb.push_back({word[TW-1:0], AW'(s), 2'(w)});
            end
        end
    endfunction

    function automatic int clear_order_errs();
        int bad = 0;
        if (clr_q.size() != NBLK) return NBLK + 1;
        for (int i = 0; i < NBLK; i++) if (clr_q[i] != 4'(i)) bad++;
        return bad;
    endfunction

    function automatic int nonzero_blocks();
        int nz = 0;
        for (int i = 0; i < NBLK; i++) if (mem[i] !== 32'd0) nz++;
        return nz;
    endfunction

    function automatic int wb_list_errs();
        int bad = 0;
        if (wb_q.size() != exp_wb.size()) return 1000;
        for (int i = 0; i < exp_wb.size(); i++) if (wb_q[i] !== exp_wb[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.sel !== 1'b0) $display("FAIL rst_sel: got %b want 0", bus.sel); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.ri_writeEnable !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.ri_writeEnable); else n_pass++;
        n_checks++; if (bus.wb_count !== '0) $display("FAIL rst_wb_count: got %0d want 0", bus.wb_count); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_flush_single(input int stall);
        int  bad;
        bit  to;
        int  exp_cycles;
        for (int i = 0; i < NBLK; i++) begin
            case ($urandom_range(0, 2))
                0: img[i] = {9'd0, 2'b00, 21'($urandom)};
                1: img[i] = {9'd0, 2'b01, 21'($urandom)};
                default: img[i] = {9'd0, 2'b10, 21'($urandom)};
            endcase
        end
        img[0] = {9'd0, 2'b10, 21'h0F0F0};
        img[1] = {9'd0, 2'b01, 21'h12345};
        img[6] = {9'd0, 2'b11, 21'h1ABCD};
        load_image();
        stall_cfg = stall;
        run_cmd(1'b1, 0, 1'b0, bad, to);
        build_expected();
        exp_cycles = 3 * NBLK + (stall + 1) + 1;
        n_checks++; if (to !== 1'b0) $display("FAIL fl1_timeout: no done within bound"); else n_pass++;
        n_checks++; if (wb_q.size() !== 1) $display("FAIL fl1_wb_num: got %0d want 1", wb_q.size()); else n_pass++;
        n_checks++; if (wb_list_errs() !== 0) $display("FAIL fl1_wb_payload: got %h want %h", (wb_q.size() > 0) ? wb_q[0] : '0, exp_wb[0]); else n_pass++;
        n_checks++; if (bus.wb_count !== 5'd1) $display("FAIL fl1_wb_count: got %0d want 1", bus.wb_count); else n_pass++;
        n_checks++; if (stall_total !== stall + 1) $display("FAIL fl1_wb_cycles: got %0d want %0d", stall_total, stall + 1); else n_pass++;
        n_checks++; if (sel_cycles !== exp_cycles) $display("FAIL fl1_latency: got %0d want %0d", sel_cycles, exp_cycles); else n_pass++;
        n_checks++; if (clear_order_errs() !== 0) $display("FAIL fl1_clear_order: got %0d bad want 0", clear_order_errs()); else n_pass++;
        n_checks++; if (nonzero_blocks() !== 0) $display("FAIL fl1_store_clear: got %0d nonzero want 0", nonzero_blocks()); else n_pass++;
        n_checks++; if (hyg_err !== 0) $display("FAIL fl1_bus_hygiene: got %0d want 0", hyg_err); else n_pass++;
    endtask

    task automatic test_invalidate();
        int bad;
        bit to;
        int exp_cycles;
        for (int i = 0; i < NBLK; i++) img[i] = $urandom;
        load_image();
        run_cmd(1'b0, 0, 1'b0, bad, to);
        exp_cycles = 4 * NSET + 1;
        n_checks++; if (to !== 1'b0) $display("FAIL inv_timeout: no done within bound"); else n_pass++;
        n_checks++; if (sel_cycles !== exp_cycles) $display("FAIL inv_latency: got %0d want %0d", sel_cycles, exp_cycles); else n_pass++;
        n_checks++; if (clear_order_errs() !== 0) $display("FAIL inv_clear_order: got %0d bad want 0", clear_order_errs()); else n_pass++;
        n_checks++; if (wb_q.size() !== 0) $display("FAIL inv_no_wb: got %0d want 0", wb_q.size()); else n_pass++;
        n_checks++; if (bus.wb_count !== '0) $display("FAIL inv_wb_count: got %0d want 0", bus.wb_count); else n_pass++;
        n_checks++; if (nonzero_blocks() !== 0) $display("FAIL inv_store_clear: got %0d nonzero want 0", nonzero_blocks()); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL inv_done_pulse: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL inv_idle_after: got busy=%b ready=%b want 0/1", bus.busy, bus.cmd_ready); else n_pass++;
    endtask

    task automatic test_flush_random();
        int bad;
        bit to;
        int exp_cycles;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NBLK; i++) img[i] = $urandom;
            load_image();
            build_expected();
            stall_cfg = -1;
            run_cmd(1'b1, 0, 1'b0, bad, to);
            exp_cycles = 3 * NBLK + stall_total + 1;
            n_checks++; if (to !== 1'b0) $display("FAIL flr_timeout: iter %0d no done", it); else n_pass++;
            n_checks++; if (wb_list_errs() !== 0) $display("FAIL flr_wb_list: iter %0d got %0d entries want %0d", it, wb_q.size(), exp_wb.size()); else n_pass++;
            n_checks++; if (bus.wb_count !== 5'(exp_wb.size())) $display("FAIL flr_wb_count: got %0d want %0d", bus.wb_count, exp_wb.size()); else n_pass++;
            n_checks++; if (sel_cycles !== exp_cycles) $display("FAIL flr_latency: got %0d want %0d", sel_cycles, exp_cycles); else n_pass++;
            n_checks++; if (clear_order_errs() !== 0) $display("FAIL flr_clear_order: got %0d bad want 0", clear_order_errs()); else n_pass++;
            n_checks++; if (nonzero_blocks() !== 0) $display("FAIL flr_store_clear: got %0d nonzero want 0", nonzero_blocks()); else n_pass++;
            n_checks++; if (hyg_err !== 0) $display("FAIL flr_bus_hygiene: got %0d want 0", hyg_err); else n_pass++;
            repeat (3) @(negedge clk);
            n_checks++; if (bus.wb_count !== 5'(exp_wb.size())) $display("FAIL flr_wb_count_hold: got %0d want %0d", bus.wb_count, exp_wb.size()); else n_pass++;
        end
    endtask

    task automatic test_rw_wait();
        int bad;
        bit to;
        int idle_busy;
        for (int i = 0; i < NBLK; i++) img[i] = $urandom;
        load_image();
        run_cmd(1'b0, 4, 1'b1, bad, to);
        n_checks++; if (to !== 1'b0) $display("FAIL rww_timeout: no done within bound"); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL rww_wait_bus: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (sel_cycles !== 4 * NSET + 1) $display("FAIL rww_latency: got %0d want %0d", sel_cycles, 4 * NSET + 1); else n_pass++;
        n_checks++; if (clear_order_errs() !== 0) $display("FAIL rww_clear_order: got %0d bad want 0", clear_order_errs()); else n_pass++;
        idle_busy = 0;
        repeat (4) begin
            if (bus.busy || bus.sel) idle_busy++;
            @(negedge clk);
        end
        n_checks++; if (idle_busy !== 0) $display("FAIL rww_not_queued: got %0d busy cycles want 0", idle_busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        bit to;
        bit got;
        for (int i = 0; i < NBLK; i++) img[i] = {9'd0, 2'b11, 21'($urandom)};
        load_image();
        clear_mon();
        stall_cfg = 50;
        @(negedge clk);
        bus.rw_idle = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.wb_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++; if (got !== 1'b1) $display("FAIL rstm_reach_wb: wb_valid never seen"); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.sel !== 1'b0) $display("FAIL rstm_sel: got %b want 0", bus.sel); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL rstm_wb_valid: got %b want 0", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstm_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rstm_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        n_checks++; if (bus.ri_writeEnable !== 1'b0) $display("FAIL rstm_we: got %b want 0", bus.ri_writeEnable); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = -1;
        run_cmd(1'b0, 0, 1'b0, bad, to);
        n_checks++; if (to !== 1'b0) $display("FAIL rstm_inv_timeout: no done within bound"); else n_pass++;
        n_checks++; if (sel_cycles !== 4 * NSET + 1) $display("FAIL rstm_inv_latency: got %0d want %0d", sel_cycles, 4 * NSET + 1); else n_pass++;
        n_checks++; if (nonzero_blocks() !== 0) $display("FAIL rstm_store_clear: got %0d nonzero want 0", nonzero_blocks()); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        bus.rw_idle = 1'b1;
        test_reset();
        test_flush_single(0);
        test_invalidate();
        test_flush_single(5);
        test_flush_random();
        test_rw_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
